// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage types and constants.
// Bus widths, default NOP/reset PC and FSM encodings.
package if_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] inst_t;
  typedef logic [XLEN-1:0] addr_t;

  localparam inst_t DEF_NOP_INST = 32'h0000_0013;
  localparam addr_t DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    FLUSH = 2'b10
  } fetch_state_e;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } if_id_t;

  function automatic addr_t align_pc(addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory bus plus
// decode-side handshake of the fetch stage.
interface if_stage_if;
  import if_stage_pkg::*;

  logic  imem_req_o;
  addr_t imem_addr_o;
  logic  imem_ack_i;
  inst_t imem_rdata_i;
  logic  stall_i;
  logic  redirect_i;
  addr_t redirect_pc_i;
  addr_t if_pc_o;
  inst_t if_inst_o;
  logic  if_valid_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    output if_pc_o,
    output if_inst_o,
    output if_valid_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i,
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    input  if_pc_o,
    input  if_inst_o,
    input  if_valid_o
  );

endinterface

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry {pc,inst} holding buffer
// used while decode is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  logic   unload,
  input  if_id_t din,
  output logic   full,
  output if_id_t dout
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM with output
// register and skid entry for decode back-pressure.
module if_stage
  import if_stage_pkg::*;
#(
  parameter addr_t RESET_PC = DEF_RESET_PC,
  parameter inst_t NOP_INST = DEF_NOP_INST
) (
  input  logic clk,
  input  logic rst,
  if_stage_if.master bus
);

  fetch_state_e state;
  addr_t  pc_q;
  addr_t  req_addr_q;
  logic   out_valid_q;
  if_id_t out_q;
  logic   skid_full;
  if_id_t skid_q;

  logic   ack;
  logic   redir;
  logic   deliver;
  logic   blocked;
  logic   unload;
  logic   skid_load;
  logic   skid_full_nxt;
  addr_t  tgt;
  addr_t  pc_inc;
  if_id_t fetched;

  // acks outside a live request are ignored
  assign ack     = (state != IDLE) && bus.imem_ack_i;
  assign redir   = bus.redirect_i;
  assign tgt     = align_pc(bus.redirect_pc_i);
  assign pc_inc  = pc_q + 32'd4;
  assign deliver = (state == FETCH) && ack && !redir;
  assign blocked = out_valid_q && bus.stall_i;
  assign fetched = {req_addr_q, bus.imem_rdata_i};

  assign unload    = skid_full && !blocked && !redir;
  assign skid_load = deliver && blocked;
  assign skid_full_nxt = !redir &&
    (skid_load || (skid_full && !unload));

  if_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (redir),
    .load   (skid_load),
    .unload (unload),
    .din    (fetched),
    .full   (skid_full),
    .dout   (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q.pc    <= '0;
      out_q.inst  <= NOP_INST;
    end else if (redir) begin
      out_valid_q <= 1'b0;
      out_q.inst  <= NOP_INST;
    end else if (!blocked) begin
      if (skid_full) begin
        out_valid_q <= 1'b1;
        out_q       <= skid_q;
      end else if (deliver) begin
        out_valid_q <= 1'b1;
        out_q       <= fetched;
      end else begin
        out_valid_q <= 1'b0;
        out_q.inst  <= NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir) begin
            pc_q       <= tgt;
            req_addr_q <= tgt;
            state      <= FETCH;
          end else if (!skid_full_nxt) begin
            req_addr_q <= pc_q;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (redir) begin
            pc_q <= tgt;
            if (ack) begin
              req_addr_q <= tgt;
            end else begin
              state <= FLUSH;
            end
          end else if (ack) begin
            pc_q <= pc_inc;
            if (skid_full_nxt) begin
              state <= IDLE;
            end else begin
              req_addr_q <= pc_inc;
            end
          end
        end
        FLUSH: begin
          // old request must finish before refetch
          if (redir) begin
            pc_q <= tgt;
          end
          if (ack) begin
            req_addr_q <= redir ? tgt : pc_q;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req_o  = (state != IDLE);
  assign bus.imem_addr_o = req_addr_q;
  assign bus.if_valid_o  = out_valid_q;
  assign bus.if_pc_o     = out_q.pc;
  assign bus.if_inst_o   = out_q.inst;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a queue
// scoreboard on instructions accepted by decode.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;

  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     nvec = 0;
  int     nerr = 0;
  if_id_t exp_q[$];
  bit     mem_on;
  int     mem_delay;
  int     wcnt;

  function automatic inst_t mem(addr_t a);
    return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'h00FF};
  endfunction

  task automatic expect_pc(addr_t pc);
    if_id_t e;
    e.pc   = pc;
    e.inst = mem(pc);
    exp_q.push_back(e);
  endtask

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // one clock; memory responds after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (!mem_on || bus.imem_req_o !== 1'b1) begin
      bus.imem_ack_i = 1'b0;
      wcnt = 0;
    end else if (wcnt >= mem_delay) begin
      bus.imem_ack_i = 1'b1;
      wcnt = 0;
    end else begin
      bus.imem_ack_i = 1'b0;
      wcnt++;
    end
    bus.imem_rdata_i = bus.imem_ack_i ?
      mem(bus.imem_addr_o) : 32'hDEAD_BEEF;
  endtask

  always @(negedge clk) begin
    if_id_t e;
    if (bus.if_valid_o === 1'b1 &&
        bus.stall_i === 1'b0 &&
        bus.redirect_i === 1'b0) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL sb_extra: got pc %h, want none",
                 bus.if_pc_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.if_pc_o !== e.pc ||
            bus.if_inst_o !== e.inst) begin
          nerr++;
          $display("FAIL sb_inst: got %h/%h want %h/%h",
                   bus.if_pc_o, bus.if_inst_o,
                   e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_ack_i = 1'b0;
    bus.imem_rdata_i = '0;
    mem_on = 1'b1;
    mem_delay = 0;
    wcnt = 0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_valid", bus.if_valid_o, 0);
    chk("rst_inst", bus.if_inst_o, 32'h13);
    chk("rst_pc", bus.if_pc_o, 0);

    // zero-wait stream
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    step();
    chk("t1_req", bus.imem_req_o, 1);
    chk("t1_addr0", bus.imem_addr_o, 32'h0);
    step();
    chk("t1_valid", bus.if_valid_o, 1);
    chk("t1_pc0", bus.if_pc_o, 32'h0);
    chk("t1_addr4", bus.imem_addr_o, 32'h4);
    step();
    chk("t1_pc4", bus.if_pc_o, 32'h4);
    chk("t1_addr8", bus.imem_addr_o, 32'h8);
    mem_on = 1'b0;
    step();
    chk("t1_addrc", bus.imem_addr_o, 32'hC);
    step();
    chk("t1_drain", bus.if_valid_o, 0);
    chk("t1_nop", bus.if_inst_o, 32'h13);

    // three wait states
    mem_on = 1'b1;
    mem_delay = 3;
    expect_pc(32'hC);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_addr_hold", bus.imem_addr_o, 32'hC);
      chk("t2_req_hold", bus.imem_req_o, 1);
      chk("t2_wait_valid", bus.if_valid_o, 0);
    end
    step();
    chk("t2_valid", bus.if_valid_o, 1);
    chk("t2_pc", bus.if_pc_o, 32'hC);
    chk("t2_next", bus.imem_addr_o, 32'h10);
    mem_on = 1'b0;
    step();

    // stall for four cycles
    mem_delay = 0;
    mem_on = 1'b1;
    expect_pc(32'h10);
    expect_pc(32'h14);
    expect_pc(32'h18);
    expect_pc(32'h1C);
    step();
    step();
    chk("t3_pc10", bus.if_pc_o, 32'h10);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_drop", bus.imem_req_o, 0);
      chk("t3_hold_pc", bus.if_pc_o, 32'h10);
      chk("t3_hold_v", bus.if_valid_o, 1);
    end
    step();
    bus.stall_i = 1'b0;
    step();
    chk("t3_skid_pc", bus.if_pc_o, 32'h14);
    chk("t3_resume", bus.imem_addr_o, 32'h18);
    step();
    chk("t3_pc18", bus.if_pc_o, 32'h18);
    mem_on = 1'b0;
    step();
    chk("t3_pc1c", bus.if_pc_o, 32'h1C);

    // redirect while request waits
    mem_on = 1'b1;
    mem_delay = 2;
    expect_pc(32'h100);
    step();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    step();
    bus.redirect_i = 1'b0;
    chk("t4_old_addr", bus.imem_addr_o, 32'h20);
    chk("t4_old_req", bus.imem_req_o, 1);
    chk("t4_flush_v", bus.if_valid_o, 0);
    chk("t4_flush_nop", bus.if_inst_o, 32'h13);
    step();
    step();
    chk("t4_new_addr", bus.imem_addr_o, 32'h100);
    chk("t4_discard", bus.if_valid_o, 0);
    step();
    step();
    chk("t4_wait_v", bus.if_valid_o, 0);
    step();
    chk("t4_valid", bus.if_valid_o, 1);
    chk("t4_pc", bus.if_pc_o, 32'h100);
    mem_on = 1'b0;
    step();

    // redirect with stall and full skid
    mem_on = 1'b1;
    mem_delay = 0;
    expect_pc(32'h200);
    expect_pc(32'h204);
    step();
    step();
    bus.stall_i = 1'b1;
    step();
    chk("t5_full_req", bus.imem_req_o, 0);
    chk("t5_hold", bus.if_pc_o, 32'h104);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h200;
    step();
    bus.redirect_i = 1'b0;
    bus.stall_i = 1'b0;
    chk("t5_flush_v", bus.if_valid_o, 0);
    chk("t5_flush_nop", bus.if_inst_o, 32'h13);
    chk("t5_addr", bus.imem_addr_o, 32'h200);
    step();
    chk("t5_pc", bus.if_pc_o, 32'h200);
    mem_on = 1'b0;
    step();
    step();

    // address wrap
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    step();
    bus.redirect_i = 1'b0;
    mem_on = 1'b1;
    step();
    step();
    chk("t6_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap", bus.imem_addr_o, 32'h0);
    chk("t6_pc", bus.if_pc_o, 32'hFFFF_FFFC);
    mem_on = 1'b0;
    step();
    chk("t6_pc0", bus.if_pc_o, 32'h0);
    chk("t6_v", bus.if_valid_o, 1);

    // reset mid-request, stray ack ignored
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_ack_i = 1'b1;
    bus.imem_rdata_i = 32'hBAD0_BAD0;
    chk("t7_req", bus.imem_req_o, 0);
    chk("t7_valid", bus.if_valid_o, 0);
    chk("t7_nop", bus.if_inst_o, 32'h13);
    chk("t7_pc", bus.if_pc_o, 0);
    expect_pc(32'h0);
    step();
    chk("t7_addr", bus.imem_addr_o, 32'h0);
    chk("t7_req1", bus.imem_req_o, 1);
    chk("t7_ignored", bus.if_valid_o, 0);
    mem_on = 1'b1;
    step();
    mem_on = 1'b0;
    step();
    chk("t7_v", bus.if_valid_o, 1);
    chk("t7_pc0", bus.if_pc_o, 32'h0);
    chk("t7_next", bus.imem_addr_o, 32'h4);
    step();
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), value driven on if_inst_o when no valid instruction is held.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req_o  output  1  instruction-memory request.
REQ-006 imem_addr_o  output  32  word-aligned fetch address.
REQ-007 imem_ack_i  input  1  memory completion; data valid in the ack cycle; may arrive in the request cycle or any later cycle.
REQ-008 imem_rdata_i  input  32  fetched instruction.
REQ-009 stall_i  input  1  decode cannot accept; hold IF/ID outputs.
REQ-010 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc_i  input  32  target address.
REQ-012 if_pc_o  output  32  PC of instruction on if_inst_o.
REQ-013 if_inst_o  output  32  instruction to decode/control.
REQ-014 if_valid_o  output  1  if_pc_o/if_inst_o hold a live instruction.

Function
REQ-015 FSM states IDLE, FETCH, FLUSH; state, pc_q, req_addr_q, output register and skid entry all registered.
REQ-016 IDLE: imem_req_o=0; go FETCH next cycle when skid empty and no stall-induced full condition, capturing req_addr_q<=pc_q.
REQ-017 FETCH/FLUSH: imem_req_o=1, imem_addr_o=req_addr_q, both held stable until the ack cycle (request never withdrawn).
REQ-018 FETCH ack, no redirect: deliver {req_addr_q, imem_rdata_i}; pc_q<=pc_q+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 Delivery goes to output register when if_valid_o=0 or stall_i=0; otherwise into the one-entry skid.
REQ-020 After a FETCH ack, stay FETCH (issuing pc_q+4 next cycle) unless the skid became or remains full, then go IDLE; zero-wait memory yields one instruction per cycle.
REQ-021 Latency: ack in cycle N -> if_valid_o=1 with that instruction in cycle N+1 (when not blocked).
REQ-022 stall_i=1 with if_valid_o=1: if_pc_o, if_inst_o, if_valid_o unchanged.
REQ-023 stall_i=0: output register loads skid entry if present, else the delivered instruction, else if_valid_o<=0 and if_inst_o<=NOP_INST.
REQ-024 redirect_i=1 (any state, overrides stall_i): next cycle if_valid_o=0, if_inst_o=NOP_INST, skid empty; pc_q<=redirect_pc_i with bits[1:0] forced to 0.
REQ-025 Redirect in FETCH with ack same cycle: discard data, go FETCH at new pc_q.
REQ-026 Redirect in FETCH without ack: go FLUSH, keep request on old req_addr_q.
REQ-027 FLUSH ack: discard data, go FETCH at pc_q; further redirects in FLUSH only update pc_q.
REQ-028 Redirect in IDLE: go FETCH at redirected pc_q next cycle.
REQ-029 Skid never overflows: no request issued while skid full.

Reset
REQ-030 With rst=1 at a clock edge: state=IDLE, pc_q=RESET_PC, req_addr_q=RESET_PC, skid empty, if_valid_o=0, if_inst_o=NOP_INST, if_pc_o=0.
REQ-031 imem_req_o=0 during reset and the first cycle after; first request RESET_PC in the second cycle after rst falls.
REQ-032 Reset mid-request abandons it; a late ack arriving in IDLE is ignored.

Structure
REQ-033 InstBus/AddrBus widths, NOP_INST, default RESET_PC and FSM state encodings live in the shared defines file.
REQ-034 One sub-module, if_skid_buf: one-entry {pc,inst} buffer with load/unload/flush and full flag.

Verification
REQ-035 Reset, then zero-wait acks -> requests 0x0,0x4,0x8; if_valid_o high from the cycle after first ack, PCs 0x0,0x4,0x8 consecutive.
REQ-036 Ack delayed 3 cycles -> imem_addr_o stable 4 cycles, instruction appears cycle after ack.
REQ-037 stall_i high 4 cycles, zero-wait memory -> output held, skid takes one instruction, req drops; after release instructions in order, none lost or duplicated.
REQ-038 redirect_i to 0x0000_0103 while a request waits 2 cycles -> old data discarded, next request 0x0000_0100, if_valid_o=0 until its ack.
REQ-039 redirect_i with stall_i=1 and skid full -> both flushed next cycle, fetch resumes at target.
REQ-040 pc_q=0xFFFF_FFFC fetched -> next request 0x0000_0000.
